mul_pipe: RTL and testbench
===========================

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter W, default 64, meaning operand/result width (even, >=8).
REQ-002 SHALL have parameter LAT, default 3, meaning issue-to-complete latency in cycles (>=1).
REQ-003 SHALL have parameter LG_ROB, default 6, meaning ROB pointer width.
REQ-004 SHALL have parameter LG_PRF, default 7, meaning PRF pointer width.
REQ-005 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port go  in  1  issue strobe, accepted when go & ready & ~flush.
REQ-008 SHALL have port op  in  2  00 MUL(low), 01 MULH(s*s), 10 MULHSU(s*u), 11 MULHU(u*u).
REQ-009 SHALL have port is_word  in  1  half-width op: low W/2 of product, sign-extended.
REQ-010 SHALL have ports src_a, src_b  in  W  operands.
REQ-011 SHALL have ports rob_ptr_in  in  LG_ROB and prf_ptr_in  in  LG_PRF  tags.
REQ-012 SHALL have port prf_val_in  in  1  destination register valid.
REQ-013 SHALL have port stall  in  1  writeback port busy; freezes entire pipeline.
REQ-014 SHALL have port flush  in  1  discards all in-flight ops.
REQ-015 SHALL have port ready  out  1  equals ~stall.
REQ-016 SHALL have ports y  out  W, complete  out  1, rob_ptr_out  out  LG_ROB, prf_ptr_val_out  out  1, prf_ptr_out  out  LG_PRF.
REQ-017 SHALL have port busy  out  1  OR of all stage valid bits.

Function
REQ-018 SHALL form the 2W-bit product per op: a signed for 01/10, b signed for 01 only, else zero-extended.
REQ-019 SHALL select y = product[2W-1:W] for op 01/10/11, product[W-1:0] for op 00.
REQ-020 SHALL, when is_word=1, compute low W/2 bits of src_a[W/2-1:0]*src_b[W/2-1:0] sign-extended to W, regardless of op.
REQ-021 SHALL register an accepted op into stage 0 at the accepting edge and advance one stage per unstalled edge through stages 0..LAT-1.
REQ-022 SHALL assert complete = valid[LAT-1] & ~stall; y/tags/prf_ptr_val_out driven from stage LAT-1.
REQ-023 SHALL, with no stall, assert complete exactly LAT cycles after the accepting edge, for exactly one cycle per op.
REQ-024 SHALL accept one op per cycle back-to-back; results emerge in issue order.
REQ-025 SHALL hold every stage (data and valid) while stall=1; go ignored (ready=0); no op lost or duplicated.
REQ-026 SHALL, on an edge with flush=1, clear all valid bits; flush overrides stall and go; complete not asserted for flushed ops.
REQ-027 SHALL pass prf_val_in through as prf_ptr_val_out qualified by valid (0 when stage invalid).
REQ-028 SHALL keep data registers unreset; only valid bits and tags carry reset.

Reset
REQ-029 SHALL, on reset_n=0, immediately (asynchronously) clear all valid bits, rob/prf tags to 0.
REQ-030 SHALL drive complete=0, prf_ptr_val_out=0, busy=0, rob_ptr_out=0, prf_ptr_out=0 during and after reset until first completion; y don't-care while complete=0.
REQ-031 SHALL abandon ops in flight when reset asserts mid-operation; none complete after release.

Structure
REQ-032 SHALL place the op encoding typedef (mul_op_t) and default MUL_LAT constant in shared package mul_pkg.
REQ-033 SHALL instantiate sub-module mul_stage (one pipeline register with valid, hold, flush) LAT times via generate.
REQ-034 SHALL keep product formation and result select in mul_pipe; retiming of the multiplier across stages permitted by synthesis.

Verification (W=64, LAT=3)
REQ-035 SHALL test MULHU 0xFFFF_FFFF_FFFF_FFFF*0xFFFF_FFFF_FFFF_FFFF -> y=0xFFFF_FFFF_FFFF_FFFE, complete one cycle, 3 cycles after go.
REQ-036 SHALL test a=-1,b=2: MUL->0xFFFF_FFFF_FFFF_FFFE, MULH->0xFFFF_FFFF_FFFF_FFFF, MULHSU->0xFFFF_FFFF_FFFF_FFFF, MULHU->0x0000_0000_0000_0001.
REQ-037 SHALL test is_word a=0x0000_0000_8000_0000,b=1 -> y=0xFFFF_FFFF_8000_0000; a=0x1_0000_0003,b=2 -> 0x6.
REQ-038 SHALL test go on 3 consecutive cycles, stall=1 for 2 cycles mid-flight -> 3 completes in order, rob tags intact, complete=0 during stall.
REQ-039 SHALL test flush with 2 ops in flight plus go same cycle -> no complete; go next cycle completes 3 cycles later.
REQ-040 SHALL test reset_n low mid-flight -> complete/busy 0 same cycle; no completion after release.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined integer multiplier: op encoding,
// default latency and operand-signedness helpers.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  localparam int MUL_LAT = 3;

  function automatic logic op_a_signed(input mul_op_t op);
    logic sgn;
    case (op)
      OP_MULH, OP_MULHSU: sgn = 1'b1;
      default:            sgn = 1'b0;
    endcase
    return sgn;
  endfunction

  function automatic logic op_b_signed(input mul_op_t op);
    logic sgn;
    case (op)
      OP_MULH: sgn = 1'b1;
      default: sgn = 1'b0;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/mul_stage.sv
// One multiplier pipeline register: valid bit with flush/hold, reset tag,
// and an unreset data word that loads only with a valid op.
module mul_stage #(
  parameter int DW = 64,
  parameter int TW = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hold,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [TW-1:0] out_tag
);

  logic          valid_r;
  logic [DW-1:0] data_r;
  logic [TW-1:0] tag_r;

  // Valid bit: flush beats hold, hold freezes the stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (!hold) begin
      valid_r <= in_valid;
    end
  end

  // Tags stay at zero until a real op passes through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_r <= {TW{1'b0}};
    end else if (!hold && in_valid) begin
      tag_r <= in_tag;
    end
  end

  // Data word carries no reset.
  always_ff @(posedge clk) begin
    if (!hold && in_valid) begin
      data_r <= in_data;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_tag   = tag_r;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined integer multiplier (MUL/MULH/MULHSU/MULHU plus half-width form)
// with ROB/PRF tags, global stall and flush.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int W      = 64,
  parameter int LAT    = MUL_LAT,
  parameter int LG_ROB = 6,
  parameter int LG_PRF = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic [1:0]        op,
  input  logic              is_word,
  input  logic [W-1:0]      src_a,
  input  logic [W-1:0]      src_b,
  input  logic [LG_ROB-1:0] rob_ptr_in,
  input  logic [LG_PRF-1:0] prf_ptr_in,
  input  logic              prf_val_in,
  input  logic              stall,
  input  logic              flush,
  output logic              ready,
  output logic [W-1:0]      y,
  output logic              complete,
  output logic [LG_ROB-1:0] rob_ptr_out,
  output logic              prf_ptr_val_out,
  output logic [LG_PRF-1:0] prf_ptr_out,
  output logic              busy
);

  localparam int HW = W / 2;
  // Tag layout: {prf_val, prf_ptr, rob_ptr}
  localparam int TW = LG_ROB + LG_PRF + 1;

  mul_op_t        op_s;
  logic           accept_s;
  logic           a_sgn_s;
  logic           b_sgn_s;
  logic [2*W-1:0] a_ext_s;
  logic [2*W-1:0] b_ext_s;
  logic [2*W-1:0] prod_s;
  logic [HW-1:0]  wprod_s;
  logic [W-1:0]   res_s;
  logic [TW-1:0]  tag_in_s;

  logic [LAT-1:0] valid_s;
  logic [W-1:0]   data_s [LAT];
  logic [TW-1:0]  tag_s  [LAT];

  assign op_s     = mul_op_t'(op);
  assign accept_s = go & ~stall & ~flush;
  assign ready    = ~stall;
  assign tag_in_s = {prf_val_in, prf_ptr_in, rob_ptr_in};

  // Full-width product; extension to 2W makes one multiplier serve all signedness mixes.
  always_comb begin
    a_sgn_s = op_a_signed(op_s);
    b_sgn_s = op_b_signed(op_s);
    a_ext_s = {{W{a_sgn_s & src_a[W-1]}}, src_a};
    b_ext_s = {{W{b_sgn_s & src_b[W-1]}}, src_b};
    prod_s  = a_ext_s * b_ext_s;
    wprod_s = src_a[HW-1:0] * src_b[HW-1:0];
  end

  // Result select; half-width form ignores op since its low half is sign-agnostic.
  always_comb begin
    res_s = prod_s[W-1:0];
    if (is_word) begin
      res_s = {{HW{wprod_s[HW-1]}}, wprod_s};
    end else begin
      case (op_s)
        OP_MUL:                       res_s = prod_s[W-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: res_s = prod_s[2*W-1:W];
        default:                      res_s = prod_s[W-1:0];
      endcase
    end
  end

  for (genvar i = 0; i < LAT; i++) begin : g_stage
    logic          in_valid_s;
    logic [W-1:0]  in_data_s;
    logic [TW-1:0] in_tag_s;

    if (i == 0) begin : g_head
      assign in_valid_s = accept_s;
      assign in_data_s  = res_s;
      assign in_tag_s   = tag_in_s;
    end else begin : g_body
      assign in_valid_s = valid_s[i-1];
      assign in_data_s  = data_s[i-1];
      assign in_tag_s   = tag_s[i-1];
    end

    mul_stage #(
      .DW(W),
      .TW(TW)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .hold     (stall),
      .flush    (flush),
      .in_valid (in_valid_s),
      .in_data  (in_data_s),
      .in_tag   (in_tag_s),
      .out_valid(valid_s[i]),
      .out_data (data_s[i]),
      .out_tag  (tag_s[i])
    );
  end

  assign complete        = valid_s[LAT-1] & ~stall;
  assign y               = data_s[LAT-1];
  assign rob_ptr_out     = tag_s[LAT-1][LG_ROB-1:0];
  assign prf_ptr_out     = tag_s[LAT-1][LG_ROB +: LG_PRF];
  assign prf_ptr_val_out = valid_s[LAT-1] & tag_s[LAT-1][TW-1];
  assign busy            = |valid_s;

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe (W=64, LAT=3): vector table through a
// scoreboard, plus latency, stall, flush and reset sequences.
module tb_mul_pipe;

  localparam int W      = 64;
  localparam int LAT    = 3;
  localparam int LG_ROB = 6;
  localparam int LG_PRF = 7;
  localparam int NV     = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              go = 1'b0;
  logic [1:0]        op = 2'b00;
  logic              is_word = 1'b0;
  logic [W-1:0]      src_a = '0;
  logic [W-1:0]      src_b = '0;
  logic [LG_ROB-1:0] rob_ptr_in = '0;
  logic [LG_PRF-1:0] prf_ptr_in = '0;
  logic              prf_val_in = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              ready;
  logic [W-1:0]      y;
  logic              complete;
  logic [LG_ROB-1:0] rob_ptr_out;
  logic              prf_ptr_val_out;
  logic [LG_PRF-1:0] prf_ptr_out;
  logic              busy;

  typedef struct packed {
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] y;
  } vec_t;

  typedef struct packed {
    logic [63:0] y;
    logic [5:0]  rob;
    logic [6:0]  prf;
    logic        pv;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  mul_pipe #(.W(W), .LAT(LAT), .LG_ROB(LG_ROB), .LG_PRF(LG_PRF)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .op(op), .is_word(is_word),
    .src_a(src_a), .src_b(src_b), .rob_ptr_in(rob_ptr_in), .prf_ptr_in(prf_ptr_in),
    .prf_val_in(prf_val_in), .stall(stall), .flush(flush), .ready(ready), .y(y),
    .complete(complete), .rob_ptr_out(rob_ptr_out), .prf_ptr_val_out(prf_ptr_val_out),
    .prf_ptr_out(prf_ptr_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic set_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] rob);
    go = 1'b1; op = o; is_word = w; src_a = a; src_b = b;
    rob_ptr_in = rob; prf_ptr_in = {1'b1, rob}; prf_val_in = rob[0];
  endtask

  task automatic push_exp(input logic [63:0] yv, input logic [5:0] rob);
    exp_t e;
    e.y = yv; e.rob = rob; e.prf = {1'b1, rob}; e.pv = rob[0];
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s got=%0d pending want=0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor: every completion must match the oldest expected op.
  always @(negedge clk) begin
    if (complete) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_complete got rob=%0d y=%h want no completion", rob_ptr_out, y);
      end else begin
        mon_e = sb_q.pop_front();
        if (y !== mon_e.y || rob_ptr_out !== mon_e.rob || prf_ptr_out !== mon_e.prf ||
            prf_ptr_val_out !== mon_e.pv) begin
          errors++;
          $display("FAIL result got y=%h rob=%0d prf=%0d pv=%b want y=%h rob=%0d prf=%0d pv=%b",
                   y, rob_ptr_out, prf_ptr_out, prf_ptr_val_out,
                   mon_e.y, mon_e.rob, mon_e.prf, mon_e.pv);
        end
      end
    end else if (!stall) begin
      checks++;
      if (prf_ptr_val_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_prf_val got=%b want=0", prf_ptr_val_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[1]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2]  = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4]  = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h0000_0000_0000_0001};
    vecs[5]  = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h1, 64'hFFFF_FFFF_8000_0000};
    vecs[6]  = '{2'b11, 1'b1, 64'h0000_0001_0000_0003, 64'h2, 64'h0000_0000_0000_0006};
    vecs[7]  = '{2'b00, 1'b0, 64'h3, 64'h5, 64'hF};
    vecs[8]  = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[9]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000};
    vecs[10] = '{2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
    vecs[11] = '{2'b00, 1'b0, 64'h1234_5678, 64'h1_0000_0000, 64'h1234_5678_0000_0000};
    vecs[12] = '{2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
    vecs[13] = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[14] = '{2'b10, 1'b1, 64'h7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE};

    // Reset state, while reset_n is held low
    #12;
    chk("rst_complete", 64'(complete), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rob", 64'(rob_ptr_out), 64'd0);
    chk("rst_prf", 64'(prf_ptr_out), 64'd0);
    chk("rst_pv", 64'(prf_ptr_val_out), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_rob", 64'(rob_ptr_out), 64'd0);

    // Back-to-back vector table
    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      set_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 6'(i));
      push_exp(vecs[i].y, 6'(i));
      @(posedge clk); #1;
    end
    go = 1'b0;
    drain("table");

    // Latency: complete exactly 3 cycles after go, for one cycle
    @(posedge clk); #1;
    set_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd30);
    push_exp(64'hFFFF_FFFF_FFFF_FFFE, 6'd30);
    @(posedge clk); #1 go = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_complete_k%0d", k), 64'(complete), 64'(k == 2));
      chk($sformatf("lat_busy_k%0d", k), 64'(busy), 64'(k < 3));
    end
    drain("latency");

    // Three back-to-back ops, two-cycle stall mid-flight, go during stall ignored
    @(posedge clk); #1;
    set_op(2'b00, 1'b0, 64'd3, 64'd7, 6'd20); push_exp(64'd21, 6'd20);
    @(posedge clk); #1;
    set_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd21);
    push_exp(64'hFFFF_FFFF_FFFF_FFFE, 6'd21);
    @(posedge clk); #1;
    set_op(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd22);
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 6'd22);
    @(posedge clk); #1;
    stall = 1'b1;
    set_op(2'b00, 1'b0, 64'd5, 64'd5, 6'd23);
    @(negedge clk);
    chk("stall1_complete", 64'(complete), 64'd0);
    chk("stall1_ready", 64'(ready), 64'd0);
    chk("stall1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall2_complete", 64'(complete), 64'd0);
    @(posedge clk); #1;
    stall = 1'b0; go = 1'b0;
    @(negedge clk);
    chk("unstall_complete", 64'(complete), 64'd1);
    chk("unstall_rob", 64'(rob_ptr_out), 64'd20);
    drain("stall");

    // Flush with two ops in flight and go in the same cycle
    @(posedge clk); #1;
    set_op(2'b00, 1'b0, 64'd2, 64'd2, 6'd40);
    @(posedge clk); #1;
    set_op(2'b00, 1'b0, 64'd3, 64'd3, 6'd41);
    @(posedge clk); #1;
    set_op(2'b00, 1'b0, 64'd4, 64'd4, 6'd42);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    set_op(2'b00, 1'b0, 64'd6, 64'd7, 6'd43);
    push_exp(64'd42, 6'd43);
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_complete", 64'(complete), 64'd0);
    @(posedge clk); #1 go = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_flush_complete_k%0d", k), 64'(complete), 64'(k == 2));
    end
    drain("flush");

    // Asynchronous reset with ops in flight
    @(posedge clk); #1;
    set_op(2'b00, 1'b0, 64'd9, 64'd9, 6'd50);
    @(posedge clk); #1;
    set_op(2'b00, 1'b0, 64'd8, 64'd8, 6'd51);
    @(posedge clk); #1 go = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_complete", 64'(complete), 64'd0);
    chk("async_rst_pv", 64'(prf_ptr_val_out), 64'd0);
    chk("async_rst_prf", 64'(prf_ptr_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("after_rst_busy", 64'(busy), 64'd0);
    chk("after_rst_pending", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
